tone_sequencer: RTL
===================

# tone_sequencer

Multi-voice, pattern-driven audio sequencer for the pinball cabinet speaker. It replaces the fixed single-tone player with three capabilities:
- a writable song memory holding several songs;
- run-time tempo control;
- up to N simultaneous square-wave voices mixed into one 1-bit PWM stream.

The game FSM drives it with a play/stop handshake. AIN/GAIN/SHUTDOWN connect directly to the audio amplifier module.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- VOICES, 2: simultaneous voices, 1..4.
- DEPTH, 32: steps per song (power of two).
- SONGS, 4: songs in memory (power of two).
- TEMPO_W, 8: width of the tempo input.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  song-memory write strobe.
- wr_addr  in  log2(SONGS*DEPTH)  write address = {song, step}.
- wr_data  in  5*VOICES+1  step word. Bit 0 is end-of-song (EOS). Bits [5v+5:5v+1] are the note code of voice v.
- play  in  1  start request; sampled only in IDLE.
- stop  in  1  abort request; highest priority.
- song_sel  in  log2(SONGS)  song to play; latched on an accepted play.
- steps_per_sec  in  TEMPO_W  tempo; 0 is treated as 1.
- busy  out  1  high from the cycle after play is accepted until the cycle DONE is entered (low during DONE).
- done  out  1  one-cycle pulse on natural song end.
- step_idx  out  log2(DEPTH)  current step.
- AIN  out  1  mixed PWM audio.
- GAIN  out  1  constant 1.
- SHUTDOWN  out  1  equals busy; the amplifier is enabled only while playing.

## Operation
- Note codes: 0 = rest, 1..29 = C4..C8 (diatonic, same ordering as the existing player), 30..31 = rest.
- Each voice is a half-period counter that toggles its square wave when the count reaches HALF[code]-1.
  - HALF[code] = CLK_HZ/(2*freq).
  - freq for C5..C8 is the octave-4 base frequency shifted left by 1..4.
- A rest forces the voice output to 0 and clears the voice counter.
- The tempo tick comes from an accumulator:
  - each cycle, acc += max(steps_per_sec,1);
  - when acc ≥ CLK_HZ: subtract CLK_HZ and pulse tick.
  - acc is 32-bit. There is no divider.
- The mixer is a first-order sigma-delta:
  - s = number of voices currently high;
  - a' = a + s;
  - if a' ≥ VOICES, then AIN = 1 and a = a' − VOICES;
  - else AIN = 0 and a = a'.
  - All voices resting gives AIN = 0 constantly.
- FSM states: IDLE, FETCH, LOAD, PLAY, DONE.
  - IDLE: on play, latch song_sel, set step = 0, clear the tempo accumulator, go to FETCH.
  - FETCH: drive the memory read address for {song, step}. Reads are synchronous with 1-cycle latency. Go to LOAD.
  - LOAD: capture the word into the per-voice note registers, reset the voice counters, go to PLAY.
  - PLAY, on tick:
    - if EOS of the current word is set, or step == DEPTH-1: go to DONE;
    - otherwise step++ and go to FETCH.
  - DONE: pulse done, silence all voices, return to IDLE.
- stop in any non-IDLE state goes to IDLE next cycle. Voices are silenced, busy drops, and done is not pulsed.
- play while busy is ignored. play and stop together in IDLE: stop wins, so play is ignored.
- Memory writes are accepted at any time. A read and a write to the same address in the same cycle return the old data.
- Changing steps_per_sec mid-song takes effect on the next cycle's accumulation.

## Timing
- Reset values:
  - busy = 0, done = 0, step_idx = 0, AIN = 0, SHUTDOWN = 0, GAIN = 1;
  - FSM in IDLE; all accumulators and counters 0.
- Song memory is not reset.
- Play accepted at cycle t:
  - busy = 1 at t+1;
  - note registers valid at t+3;
  - first voice toggle no earlier than t+3.
- Inter-step gap: 2 cycles (FETCH, LOAD) after each tick, included in the step duration.
- Step duration = CLK_HZ/steps_per_sec cycles ±1, plus 2.
- done is asserted in the cycle after the final tick. busy falls in that same cycle.
- Reset asserted mid-song: outputs take their reset values asynchronously, and play resumes only after a new play.

## Configuration
- TONE_SEQ_LOOP_EN defined:
  - on EOS or the last step, go to FETCH with step = 0 instead of DONE;
  - done is never pulsed; only stop or reset ends playback.
- TONE_SEQ_LOOP_EN undefined: the song ends in DONE as described above.

## Structure
- Package tone_seq_pkg holds:
  - the note-code constants (REST, C4..C8);
  - the state enum;
  - a constant function half_period(code, clk_hz) that produces the HALF table.
- Sub-module tone_voice: one instance per voice, with inputs note code and load, and output square. Generated VOICES times.
- Song memory is an inferred synchronous-read RAM, SONGS*DEPTH words.

## Test plan
- Use CLK_HZ = 1000, VOICES = 2, tempo 100, with song 0 step 0 voice 0 = A4 (HALF = 1) and EOS at step 1. Play → busy at t+1, AIN toggling, done at the cycle after the second tick, SHUTDOWN follows busy.
- Write a full-depth song with no EOS → step_idx walks 0..DEPTH-1, then done after DEPTH ticks.
- Stop asserted in PLAY at step 3 → IDLE next cycle, AIN = 0, no done pulse. Play then works again.
- steps_per_sec = 0 → step duration CLK_HZ+2 cycles. Play asserted while busy → no restart, step_idx unchanged.
- Both voices on the same note → AIN duty about 50%. One voice resting → AIN duty about 25%. Both rest → AIN = 0.
- With TONE_SEQ_LOOP_EN defined: after EOS, step_idx returns to 0, no done pulse, and playback continues until reset asserted mid-note clears all outputs.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone sequencer: note codes, FSM states and the
// constant function that builds the note-code to half-period table.
package tone_seq_pkg;

    localparam int unsigned NOTE_W    = 5;
    localparam int unsigned NUM_CODES = 32;

    localparam logic [NOTE_W-1:0] REST = 5'd0;
    localparam logic [NOTE_W-1:0] C4   = 5'd1;
    localparam logic [NOTE_W-1:0] D4   = 5'd2;
    localparam logic [NOTE_W-1:0] E4   = 5'd3;
    localparam logic [NOTE_W-1:0] F4   = 5'd4;
    localparam logic [NOTE_W-1:0] G4   = 5'd5;
    localparam logic [NOTE_W-1:0] A4   = 5'd6;
    localparam logic [NOTE_W-1:0] B4   = 5'd7;
    localparam logic [NOTE_W-1:0] C5   = 5'd8;
    localparam logic [NOTE_W-1:0] C6   = 5'd15;
    localparam logic [NOTE_W-1:0] C7   = 5'd22;
    localparam logic [NOTE_W-1:0] C8   = 5'd29;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int unsigned base_freq(input int unsigned idx);
        int unsigned f;
        case (idx)
            32'd0:   f = 32'd262;
            32'd1:   f = 32'd294;
            32'd2:   f = 32'd330;
            32'd3:   f = 32'd349;
            32'd4:   f = 32'd392;
            32'd5:   f = 32'd440;
            default: f = 32'd494;
        endcase
        return f;
    endfunction

    // Rests map to 0; notes too high for the clock would give 0 and are held at 1.
    function automatic int unsigned half_period(input logic [NOTE_W-1:0] code,
                                                input int unsigned clk_hz);
        int unsigned idx;
        int unsigned oct;
        int unsigned freq;
        int unsigned half;
        if ((code == REST) || (code > C8)) begin
            half = 32'd0;
        end else begin
            idx  = 32'(code - 5'd1) % 32'd7;
            oct  = 32'(code - 5'd1) / 32'd7;
            freq = base_freq(idx) << oct;
            half = clk_hz / (32'd2 * freq);
            if (half == 32'd0) begin
                half = 32'd1;
            end else begin
                half = half;
            end
        end
        return half;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: holds a note code and toggles its output every
// HALF[code] cycles; a rest code holds the output and counter at zero.
module tone_voice
    import tone_seq_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] code,
    input  logic              load,
    output logic              square
);

    localparam int CNT_W = $clog2(CLK_HZ / 2 + 1);

    logic [CNT_W-1:0]  half_tab [NUM_CODES];
    logic [NOTE_W-1:0] note_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  half_s;
    logic              rest_s;
    logic              square_r;

    for (genvar c = 0; c < NUM_CODES; c++) begin : g_half
        assign half_tab[c] = CNT_W'(half_period(NOTE_W'(c), 32'(CLK_HZ)));
    end

    // Decode the held note into its half-period and rest flag.
    always_comb begin
        half_s = half_tab[note_r];
        rest_s = (note_r == REST) || (note_r > C8);
    end

    // Note register, half-period counter and square output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_r   <= REST;
            cnt_r    <= '0;
            square_r <= 1'b0;
        end else if (load) begin
            note_r   <= code;
            cnt_r    <= '0;
            square_r <= 1'b0;
        end else if (rest_s) begin
            cnt_r    <= '0;
            square_r <= 1'b0;
        end else if (cnt_r == (half_s - CNT_W'(1))) begin
            cnt_r    <= '0;
            square_r <= ~square_r;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    assign square = square_r;

endmodule

// File: rtl/tone_sequencer.sv
// Pattern-driven multi-voice sequencer with song RAM, tempo accumulator and
// sigma-delta voice mixer. Define TONE_SEQ_LOOP_EN to loop songs instead of ending.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int VOICES  = 2,
    parameter int DEPTH   = 32,
    parameter int SONGS   = 4,
    parameter int TEMPO_W = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [$clog2(SONGS*DEPTH)-1:0]   wr_addr,
    input  logic [5*VOICES:0]                wr_data,
    input  logic                             play,
    input  logic                             stop,
    input  logic [$clog2(SONGS)-1:0]         song_sel,
    input  logic [TEMPO_W-1:0]               steps_per_sec,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(DEPTH)-1:0]         step_idx,
    output logic                             AIN,
    output logic                             GAIN,
    output logic                             SHUTDOWN
);

    localparam int SONG_W    = $clog2(SONGS);
    localparam int STEP_W    = $clog2(DEPTH);
    localparam int WORD_W    = 5 * VOICES + 1;
    localparam int MEM_WORDS = SONGS * DEPTH;
    localparam int MIX_W     = 3;
    localparam logic [31:0]       CLK_LIMIT = 32'(CLK_HZ);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DEPTH - 1);
    localparam logic [MIX_W-1:0]  MIX_FULL  = MIX_W'(VOICES);

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic [WORD_W-1:0] word_r;

    state_t            state_r;
    state_t            state_s;
    logic [SONG_W-1:0] song_r;
    logic [STEP_W-1:0] step_r;
    logic [31:0]       acc_r;
    logic [31:0]       inc_s;
    logic [31:0]       sum_s;
    logic              tick_s;
    logic              last_s;
    logic              accept_s;
    logic              silence_s;
    logic              load_s;
    logic              busy_r;
    logic              done_r;
    logic              ain_r;
    logic [MIX_W-1:0]  mix_acc_r;
    logic [MIX_W-1:0]  ones_s;
    logic [MIX_W-1:0]  mix_sum_s;
    logic [NOTE_W-1:0] code_s [VOICES];
    logic [VOICES-1:0] square_s;

    // Song RAM write port; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read in FETCH; the word is held for LOAD and the whole PLAY step.
    always_ff @(posedge clk) begin
        if (state_r == ST_FETCH) begin
            word_r <= mem[{song_r, step_r}];
        end
    end

    // Tempo tick, end-of-song detection and play acceptance.
    always_comb begin
        inc_s    = (steps_per_sec == '0) ? 32'd1 : 32'(steps_per_sec);
        sum_s    = acc_r + inc_s;
        tick_s   = (state_r == ST_PLAY) && (sum_s >= CLK_LIMIT);
        last_s   = word_r[0] || (step_r == LAST_STEP);
        accept_s = (state_r == ST_IDLE) && play && !stop;
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: state_s = ST_LOAD;
            ST_LOAD:  state_s = ST_PLAY;
            ST_PLAY: begin
                if (tick_s) begin
`ifdef TONE_SEQ_LOOP_EN
                    state_s = ST_FETCH;
`else
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
`endif
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        if (stop) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Song/step position and tempo accumulator; the accumulator only runs in PLAY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            song_r <= '0;
            step_r <= '0;
            acc_r  <= '0;
        end else if (accept_s) begin
            song_r <= song_sel;
            step_r <= '0;
            acc_r  <= '0;
        end else if ((state_r == ST_PLAY) && !stop) begin
            if (tick_s) begin
                acc_r <= sum_s - CLK_LIMIT;
                if (!last_s) begin
                    step_r <= step_r + STEP_W'(1);
                end else begin
`ifdef TONE_SEQ_LOOP_EN
                    step_r <= '0;
`else
                    step_r <= step_r;
`endif
                end
            end else begin
                acc_r <= sum_s;
            end
        end
    end

    // Voices load the fetched notes in LOAD, and a rest whenever heading to IDLE or DONE.
    always_comb begin
        silence_s = (state_s == ST_IDLE) || (state_s == ST_DONE);
        load_s    = (state_r == ST_LOAD) || silence_s;
        for (int v = 0; v < VOICES; v++) begin
            if (silence_s) begin
                code_s[v] = REST;
            end else begin
                code_s[v] = word_r[5*v+1 +: 5];
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        tone_voice #(
            .CLK_HZ (CLK_HZ)
        ) u_voice (
            .clk    (clk),
            .reset  (reset),
            .code   (code_s[v]),
            .load   (load_s),
            .square (square_s[v])
        );
    end

    // Count of voices currently high plus the running mixer residue.
    always_comb begin
        ones_s = '0;
        for (int v = 0; v < VOICES; v++) begin
            ones_s = ones_s + MIX_W'(square_s[v]);
        end
        mix_sum_s = mix_acc_r + ones_s;
    end

    // First-order sigma-delta: emit a 1 each time the residue reaches VOICES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix_acc_r <= '0;
            ain_r     <= 1'b0;
        end else if (silence_s) begin
            mix_acc_r <= '0;
            ain_r     <= 1'b0;
        end else if (mix_sum_s >= MIX_FULL) begin
            mix_acc_r <= mix_sum_s - MIX_FULL;
            ain_r     <= 1'b1;
        end else begin
            mix_acc_r <= mix_sum_s;
            ain_r     <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign step_idx = step_r;
    assign AIN      = ain_r;
    assign GAIN     = 1'b1;
    assign SHUTDOWN = busy_r;

endmodule
